// File: rtl/vid_timing_gen.sv
// vid_timing_gen: raster position/strobe source with programmable horizontal gap.
// Define VTG_TEST_PATTERN_EN to add the registered foregnd_px test-pattern output.
module vid_timing_gen #(
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int H_BLANK      = 150,
  parameter int PRELOAD_LEAD = 2
) (
  input  logic        app_clk,
  input  logic        app_rst_n,
  input  logic        vtg_en,
  output logic [10:0] vid_hpos,
  output logic [10:0] vid_vpos,
  output logic        vid_active_pix,
  output logic        vid_preload_line,
  output logic        vid_frame_start
`ifdef VTG_TEST_PATTERN_EN
  ,
  output logic        foregnd_px
`endif
);
  typedef enum logic {HBLANK, ACTIVE} state_t;
  localparam logic [10:0] H_LAST = 11'(H_ACTIVE - 1);
  localparam logic [10:0] V_LAST = 11'(V_ACTIVE - 1);
  localparam logic [7:0]  B_LAST = 8'(H_BLANK - 1);
  localparam logic [7:0]  B_PRE  = 8'(H_BLANK - PRELOAD_LEAD);
  state_t      state_q, state_d;
  logic [10:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic [7:0]  bcnt_q, bcnt_d;
  logic        act_q, act_d, pre_q, pre_d, fs_q, fs_d;
  // Strobes are derived from the position being entered, so they sit in the
  // same registered cycle as the new position and vanish while stalled.
  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    vcnt_d  = vcnt_q;
    bcnt_d  = bcnt_q;
    if (vtg_en) begin
      if (state_q == ACTIVE) begin
        if (hcnt_q == H_LAST) begin
          state_d = HBLANK;
          hcnt_d  = '0;
          bcnt_d  = '0;
          vcnt_d  = (vcnt_q == V_LAST) ? '0 : vcnt_q + 11'd1;
        end else begin
          hcnt_d = hcnt_q + 11'd1;
        end
      end else if (bcnt_q == B_LAST) begin
        state_d = ACTIVE;
        bcnt_d  = '0;
      end else begin
        bcnt_d = bcnt_q + 8'd1;
      end
    end
    act_d = vtg_en && (state_d == ACTIVE);
    pre_d = vtg_en && (state_d == HBLANK) && (bcnt_d == B_PRE);
    fs_d  = act_d && (hcnt_d == '0) && (vcnt_d == '0);
  end
  always_ff @(posedge app_clk) begin
    if (!app_rst_n) begin
      state_q <= HBLANK;
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      bcnt_q  <= '0;
      act_q   <= 1'b0;
      pre_q   <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      bcnt_q  <= bcnt_d;
      act_q   <= act_d;
      pre_q   <= pre_d;
      fs_q    <= fs_d;
    end
  end
  assign vid_hpos         = hcnt_q;
  assign vid_vpos         = vcnt_q;
  assign vid_active_pix   = act_q;
  assign vid_preload_line = pre_q;
  assign vid_frame_start  = fs_q;
`ifdef VTG_TEST_PATTERN_EN
  logic fg_q, fg_d;
  always_comb begin
    fg_d = act_d && (
      ((vcnt_d >= 11'd6) && (vcnt_d <= 11'd99) &&
       (((hcnt_d >= 11'd21) && (hcnt_d <= 11'd200)) ||
        ((hcnt_d >= 11'd251) && (hcnt_d <= 11'd329)))) ||
      ((vcnt_d >= 11'd100) && (vcnt_d <= 11'd109) &&
       (hcnt_d >= 11'd196) && (hcnt_d <= 11'd259)));
  end
  always_ff @(posedge app_clk) begin
    if (!app_rst_n) fg_q <= 1'b0;
    else            fg_q <= fg_d;
  end
  assign foregnd_px = fg_q;
`endif
endmodule

// File: tb/tb_vid_timing_gen.sv
// tb_vid_timing_gen: scoreboard bench driving a default-size and a short-frame instance.
module tb_vid_timing_gen;
  localparam int HA = 640, VA = 480, BA = 150, PA = 2;
  localparam int SH = 340, SV = 112, SB = 10, SP = 3;
  logic        app_clk = 1'b0, app_rst_n = 1'b0, vtg_en = 1'b0;
  logic [10:0] hp_a, vp_a, hp_b, vp_b;
  logic        act_a, pre_a, fs_a, fg_a, act_b, pre_b, fs_b, fg_b;
  always #5 app_clk = ~app_clk;
  vid_timing_gen u_dut (
    .app_clk(app_clk), .app_rst_n(app_rst_n), .vtg_en(vtg_en),
    .vid_hpos(hp_a), .vid_vpos(vp_a), .vid_active_pix(act_a),
    .vid_preload_line(pre_a), .vid_frame_start(fs_a)
`ifdef VTG_TEST_PATTERN_EN
    , .foregnd_px(fg_a)
`endif
  );
  vid_timing_gen #(.H_ACTIVE(SH), .V_ACTIVE(SV), .H_BLANK(SB), .PRELOAD_LEAD(SP)) u_small (
    .app_clk(app_clk), .app_rst_n(app_rst_n), .vtg_en(vtg_en),
    .vid_hpos(hp_b), .vid_vpos(vp_b), .vid_active_pix(act_b),
    .vid_preload_line(pre_b), .vid_frame_start(fs_b)
`ifdef VTG_TEST_PATTERN_EN
    , .foregnd_px(fg_b)
`endif
  );
`ifndef VTG_TEST_PATTERN_EN
  assign fg_a = 1'b0;
  assign fg_b = 1'b0;
`endif
  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic a, p, f, g;
  } exp_t;
  exp_t qa[$], qb[$];
  int n_vec = 0, n_bad = 0;
  int pa = 0, la = 0, pb = 0, lb = 0;
  function automatic logic patt(int h, int v);
    return (v >= 6 && v <= 99 && ((h >= 21 && h <= 200) || (h >= 251 && h <= 329))) ||
           (v >= 100 && v <= 109 && h >= 196 && h <= 259);
  endfunction
  // Model: p is the phase within the line period, gap first (0..hb-1), then pixels.
  function automatic exp_t mk(int p, int l, int hb, int pl, logic e);
    exp_t x;
    x.h = (p >= hb) ? 11'(p - hb) : 11'd0;
    x.v = 11'(l);
    x.a = e && (p >= hb);
    x.p = e && (p == hb - pl);
    x.f = e && (p == hb) && (l == 0);
    x.g = x.a && patt(p - hb, l);
    return x;
  endfunction
  task automatic cyc(input logic r, input logic e);
    app_rst_n = r;
    vtg_en    = e;
    @(posedge app_clk);
    if (!r) begin
      pa = 0; la = 0; pb = 0; lb = 0;
    end else if (e) begin
      pa++;
      if (pa == HA + BA) begin pa = 0; la = (la + 1) % VA; end
      pb++;
      if (pb == SH + SB) begin pb = 0; lb = (lb + 1) % SV; end
    end
    qa.push_back(mk(pa, la, BA, PA, r && e));
    qb.push_back(mk(pb, lb, SB, SP, r && e));
    @(negedge app_clk);
  endtask
  task automatic cmp(input string nm, input exp_t x, input logic [10:0] h, input logic [10:0] v,
                     input logic a, input logic p, input logic f, input logic g);
    logic ok;
    n_vec++;
    ok = (h === x.h) && (v === x.v) && (a === x.a) && (p === x.p) && (f === x.f);
`ifdef VTG_TEST_PATTERN_EN
    ok = ok && (g === x.g);
`endif
    if (!ok) begin
      n_bad++;
      $display("FAIL %s stream: got h=%0d v=%0d act=%b pre=%b fs=%b fg=%b, want h=%0d v=%0d act=%b pre=%b fs=%b fg=%b",
               nm, h, v, a, p, f, g, x.h, x.v, x.a, x.p, x.f, x.g);
    end
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask
  always @(negedge app_clk) begin
    exp_t x, y;
    if (qa.size() > 0 && qb.size() > 0) begin
      x = qa.pop_front();
      y = qb.pop_front();
      cmp("dut", x, hp_a, vp_a, act_a, pre_a, fs_a, fg_a);
      cmp("small", y, hp_b, vp_b, act_b, pre_b, fs_b, fg_b);
    end
  end
  initial begin
    int n, pre_at, fa, fb0, fb1, wrap_seen, wrap_act;
    logic [10:0] prev_vb;
    int c50, c105, c5, c110, cgap;
    repeat (5) cyc(1'b0, 1'b1);
    chk("rst_hpos", 32'(hp_a), 0);
    chk("rst_vpos", 32'(vp_a), 0);
    chk("rst_act", 32'(act_a), 0);
    chk("rst_pre", 32'(pre_a), 0);
    chk("rst_fs", 32'(fs_a), 0);
    repeat (147) cyc(1'b1, 1'b1);
    chk("pre_edge147", 32'(pre_a), 0);
    cyc(1'b1, 1'b1);
    chk("pre_edge148", 32'(pre_a), 1);
    cyc(1'b1, 1'b1);
    chk("pre_edge149", 32'(pre_a), 0);
    chk("act_edge149", 32'(act_a), 0);
    cyc(1'b1, 1'b1);
    chk("first_hpos", 32'(hp_a), 0);
    chk("first_act", 32'(act_a), 1);
    chk("first_fs", 32'(fs_a), 1);
    repeat (300) cyc(1'b1, 1'b1);
    chk("h300", 32'(hp_a), 300);
    chk("h300_fs", 32'(fs_a), 0);
    repeat (10) begin
      cyc(1'b1, 1'b0);
      chk("stall_hpos", 32'(hp_a), 300);
      chk("stall_act", 32'(act_a), 0);
    end
    cyc(1'b1, 1'b1);
    chk("resume_hpos", 32'(hp_a), 301);
    chk("resume_act", 32'(act_a), 1);
    repeat (338) cyc(1'b1, 1'b1);
    chk("h639", 32'(hp_a), 639);
    chk("h639_vpos", 32'(vp_a), 0);
    cyc(1'b1, 1'b1);
    chk("gap_hpos", 32'(hp_a), 0);
    chk("gap_vpos", 32'(vp_a), 1);
    chk("gap_act", 32'(act_a), 0);
    repeat (147) cyc(1'b1, 1'b1);
    chk("gap_b147_pre", 32'(pre_a), 0);
    cyc(1'b1, 1'b1);
    chk("gap_b148_pre", 32'(pre_a), 1);
    repeat (5) begin
      cyc(1'b1, 1'b0);
      chk("stall_pre", 32'(pre_a), 0);
    end
    cyc(1'b1, 1'b1);
    chk("gap_b149_pre", 32'(pre_a), 0);
    chk("gap_b149_act", 32'(act_a), 0);
    cyc(1'b1, 1'b1);
    chk("line1_act", 32'(act_a), 1);
    chk("line1_hpos", 32'(hp_a), 0);
    chk("line1_vpos", 32'(vp_a), 1);
    chk("line1_fs", 32'(fs_a), 0);
    n = 0;
    while (!(vp_a == 11'd37 && hp_a == 11'd400 && act_a) && n < 40000) begin
      cyc(1'b1, 1'b1);
      n++;
    end
    chk("reach_37_400", 32'(vp_a == 11'd37 && hp_a == 11'd400), 1);
    cyc(1'b0, 1'b1);
    chk("midrst_hpos", 32'(hp_a), 0);
    chk("midrst_vpos", 32'(vp_a), 0);
    chk("midrst_act", 32'(act_a), 0);
    pre_at = -1; fa = -1; fb0 = -1; fb1 = -1; wrap_seen = 0; wrap_act = 1;
    c50 = 0; c105 = 0; c5 = 0; c110 = 0; cgap = 0;
    prev_vb = vp_b;
    for (int i = 1; i <= 45000; i++) begin
      cyc(1'b1, 1'b1);
      if (pre_a && pre_at < 0) pre_at = i;
      if (fs_a && fa < 0) fa = i;
      if (fs_b) begin
        if (fb0 < 0) fb0 = i;
        else if (fb1 < 0) fb1 = i;
      end
      if (prev_vb == 11'(SV - 1) && vp_b == 11'd0) begin
        wrap_seen = 1;
        wrap_act = 32'(act_b);
      end
      prev_vb = vp_b;
      if (fg_b && vp_b == 11'd50) c50++;
      if (fg_b && vp_b == 11'd105) c105++;
      if (fg_b && vp_b == 11'd5) c5++;
      if (fg_b && vp_b == 11'd110) c110++;
      if (fg_b && !act_b) cgap++;
      if (fb1 >= 0) break;
    end
    chk("replay_pre_edge", 32'(pre_at), 148);
    chk("replay_first_px", 32'(fa), 150);
    chk("small_first_fs", 32'(fb0), 10);
    chk("small_frame_period", 32'(fb1 - fb0), SV * (SH + SB));
    chk("small_vwrap_seen", 32'(wrap_seen), 1);
    chk("small_vwrap_act", 32'(wrap_act), 0);
`ifdef VTG_TEST_PATTERN_EN
    chk("fg_v50_count", 32'(c50), 259);
    chk("fg_v105_count", 32'(c105), 64);
    chk("fg_v5_count", 32'(c5), 0);
    chk("fg_v110_count", 32'(c110), 0);
    chk("fg_gap_count", 32'(cgap), 0);
`endif
    repeat (2) @(negedge app_clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/vid_timing_gen.md
# vid_timing_gen

Raster timing source for the motion-segmentation node: produces the `vid_hpos`/`vid_vpos`/`vid_active_pix`/`vid_preload_line` stream consumed by `blob_analyzer` and the other per-pixel stages. It is the transmitting end of the video-position interface those stages receive. It generates a 640x480 active raster with a programmable horizontal gap and no vertical blanking. An optional built-in foreground test pattern allows bring-up without a camera.

## Interface
- `H_ACTIVE`, 640: active pixels per line (1..2047).
- `V_ACTIVE`, 480: active lines per frame (1..2047).
- `H_BLANK`, 150: blank cycles after each line (2..255).
- `PRELOAD_LEAD`, 2: cycles between the `vid_preload_line` pulse and the first active pixel of the next line (1..H_BLANK-1).

Ports:
- `app_clk`  in  1  sole clock; all logic on its rising edge.
- `app_rst_n`  in  1  synchronous, active-low reset.
- `vtg_en`  in  1  advance enable; low freezes the raster position.
- `vid_hpos`  out  11  current pixel column.
- `vid_vpos`  out  11  current line.
- `vid_active_pix`  out  1  high while the position is an active pixel.
- `vid_preload_line`  out  1  one-cycle pulse announcing the next line.
- `vid_frame_start`  out  1  one-cycle pulse on pixel (0,0).
- `foregnd_px`  out  1  test-pattern pixel. Present only with `VTG_TEST_PATTERN_EN`.

## Operation
- FSM `ACTIVE` / `HBLANK`.
- Counters: `hcnt` (11 b) and `vcnt` (11 b) for position, and `bcnt` (8 b) for blank.
- Reset state is blank position b=0 of the gap preceding line 0. All outputs are 0, with `vid_hpos`=0 and `vid_vpos`=0.
- Each `app_clk` edge with `vtg_en`=1 advances exactly one position.
- `ACTIVE`: `vid_hpos` steps 0..H_ACTIVE-1 and `vid_active_pix`=1.
- `ACTIVE` -> `HBLANK` after `hpos`=H_ACTIVE-1. On entering the gap:
  - `vid_hpos` becomes 0 and holds 0 for the whole gap.
  - `vid_vpos` increments, wrapping V_ACTIVE-1 -> 0 on the same edge.
  - `vid_active_pix`=0.
- `HBLANK`: `bcnt` runs 0..H_BLANK-1. `vid_preload_line`=1 only at b = H_BLANK-PRELOAD_LEAD.
- `HBLANK` -> `ACTIVE` after b=H_BLANK-1.
- `vid_frame_start`=1 exactly on the active position hpos=0, vpos=0.
- Line period is H_ACTIVE+H_BLANK enabled cycles; frame period is V_ACTIVE times that.
- Strobes (`vid_active_pix`, `vid_preload_line`, `vid_frame_start`, `foregnd_px`) are high only in the single cycle following the enabled edge that entered the position. While `vtg_en`=0:
  - position outputs hold;
  - all strobes are 0;
  - no pixel or pulse is ever emitted twice.
- Reset asserted at any point, mid-line or mid-gap, returns to the reset state on that edge. After release, line 0 restarts with a full H_BLANK gap and its preload pulse.
- Reset takes priority over `vtg_en`.
- No arithmetic overflow:
  - `hcnt` compares against H_ACTIVE-1 before incrementing;
  - `vcnt` compares against V_ACTIVE-1;
  - `bcnt` compares against H_BLANK-1.

## Timing
- All outputs are registered and change only on `app_clk` rising edges. There is no combinational path from input to output.
- After reset release with `vtg_en` held high, the first active pixel (0,0) appears H_BLANK cycles after the first enabled edge. `vid_preload_line` pulses PRELOAD_LEAD cycles before it.
- `vid_vpos` is already the new line value during that line's preceding gap and preload pulse.
- `vtg_en` latency: a deassertion sampled on edge N freezes the outputs shown after edge N.

## Configuration
- `VTG_TEST_PATTERN_EN` defined: adds the registered `foregnd_px` output, aligned with the position outputs.
  - `foregnd_px`=1 when `vid_active_pix`=1 and either condition holds:
    - 6<=vpos<=99 and (21<=hpos<=200 or 251<=hpos<=329);
    - 100<=vpos<=109 and 196<=hpos<=259.
  - Otherwise `foregnd_px`=0. The reset value is 0.
- `VTG_TEST_PATTERN_EN` undefined: the `foregnd_px` port and its logic are absent. All other behaviour is identical.

## Test plan
- Reset and first line: hold `app_rst_n`=0 for 5 cycles, then release with `vtg_en`=1.
  - Outputs are all 0 during reset.
  - `vid_preload_line` pulses on enabled edge 148.
  - Edge 150 shows hpos=0, vpos=0, `vid_active_pix`=1, `vid_frame_start`=1.
- Line wrap: observe hpos 639.
  - The next cycle shows hpos=0, vpos+1, `vid_active_pix`=0.
  - This gap lasts exactly 150 cycles and contains one preload pulse.
- Frame wrap: after 480 lines, vpos goes 479 -> 0 entering the gap. The next line's pixel 0 carries `vid_frame_start`=1, and the period is 480*790 cycles.
- Stall: drop `vtg_en` for 10 cycles at hpos=300.
  - hpos holds 300 and `vid_active_pix`=0 during the stall.
  - After re-enable, hpos resumes at 301 with no repeated pixel.
  - Repeat the stall on the preload cycle: the pulse is seen once.
- Mid-line reset: assert `app_rst_n`=0 for 1 cycle at hpos=400, vpos=37. Outputs return to 0 and the full 150-cycle gap is replayed before (0,0).
- Pattern (macro defined): at vpos=50, `foregnd_px` is high for hpos 21..200 and 251..329. At vpos=105 it is high for 196..259. It is 0 at vpos=5 and vpos=110, and 0 throughout every gap.
